enemy_spawn_ctrl: RTL and testbench
===================================

// Module: enemy_spawn_ctrl
// PURPOSE
//  Decides when the next enemy vehicle enters the road, whether it is a car or a
//  truck, and in which lane. Sits directly upstream of the car/truck object mux:
//  drives its create_truck / object_ready inputs, and gives spawn_x to the car
//  and truck object blocks. Frame-paced by startOfFrame; randomness from an LFSR.
// PARAMETERS
//  MIN_GAP_FRAMES   30       minimum frames between object leaving and next spawn (>=1)
//  GAP_RANGE_LOG2   5        random extra gap 0..2^N-1 frames (0 = fixed gap)
//  TRUCK_THRESH     9'd64    truck when lfsr[15:8] < TRUCK_THRESH (0=never, 256=always)
//  LANE_BITS        2        lanes = 2^LANE_BITS
//  LANE_X0          11'd160  x of lane 0 (pixels)
//  LANE_W           11'd64   lane pitch (pixels)
//  LFSR_SEED        16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  clk            in   1   system clock
//  resetN         in   1   asynchronous, active-low reset
//  startOfFrame   in   1   one-cycle pulse per VGA frame
//  game_enable    in   1   1 = gameplay running; 0 = freeze spawning
//  object_exited  in   1   current enemy left the screen (pulse)
//  object_hit     in   1   current enemy destroyed by collision (pulse)
//  object_ready   out  1   one-cycle pulse: new enemy spawned this cycle
//  create_truck   out  1   1 = spawned enemy is a truck; held until next spawn
//  spawn_x        out  11  top-left x of spawned enemy; held until next spawn
//  active         out  1   1 while an enemy is on screen (state ACTIVE)
//  spawn_count    out  8   enemies spawned since reset, saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE, lfsr=LFSR_SEED, gap_cnt=0, object_ready=0, create_truck=0,
//   spawn_x=LANE_X0, active=0, spawn_count=0. All outputs registered.
//  LFSR: 16-bit Galois, mask 16'hB400, shifts every clk when out of reset, any state.
//  States: IDLE, GAP, SPAWN, ACTIVE.
//  IDLE:   game_enable=1 -> GAP; gap_cnt <= MIN_GAP_FRAMES + lfsr[GAP_RANGE_LOG2-1:0].
//  GAP:    on startOfFrame: gap_cnt<=1 -> SPAWN, else gap_cnt--. Load L => spawn on Lth sof.
//          On GAP->SPAWN edge latch create_truck=(lfsr[15:8]<TRUCK_THRESH),
//          spawn_x=LANE_X0+lfsr[LANE_BITS-1:0]*LANE_W (11-bit, no overflow check).
//  SPAWN:  one cycle; object_ready=1; spawn_count++ (sat 255); -> ACTIVE.
//          create_truck/spawn_x already valid in this cycle and stable afterwards.
//  ACTIVE: active=1; object_exited|object_hit -> GAP with fresh random reload.
//  object_exited/object_hit ignored in IDLE, GAP, SPAWN. Both together = one event.
//  startOfFrame coincident with leaving ACTIVE is not counted toward the new gap.
//  game_enable=0 in any state (highest priority) -> IDLE next edge: object_ready=0,
//   active=0; create_truck, spawn_x, spawn_count hold. Spawn pending in SPAWN aborted.
//  Re-enable always restarts from a full gap reload (no resume of partial gap).
//  resetN mid-operation: immediate return to reset values, including LFSR.
// TESTING
//  1 Reset: hold resetN=0 -> all outputs at reset values, object_ready never 1.
//  2 GAP_RANGE_LOG2=0, MIN_GAP_FRAMES=30, enable -> object_ready pulses exactly 1 clk,
//    on edge after the 30th sof; spawn_count=1; active=1 next cycle.
//  3 TRUCK_THRESH=0 -> 20 spawns all create_truck=0; TRUCK_THRESH=256 -> all 1;
//    spawn_x always in {160,224,288,352}.
//  4 In ACTIVE pulse object_hit with sof same cycle -> GAP; next spawn after 30 more sofs;
//    exited pulses during GAP are ignored (no early spawn).
//  5 Drop game_enable at gap_cnt=10 -> IDLE, outputs held; re-enable -> full 30-frame gap.
//  6 Force 300 spawns (MIN_GAP_FRAMES=1) -> spawn_count saturates at 255.

Source files
------------

// File: rtl/enemy_spawn_ctrl.sv
// Enemy spawn controller: paces new enemies by frame count, then picks the
// vehicle type (car/truck) and lane from a free-running Galois LFSR.
// Drives create_truck/object_ready to the object mux and spawn_x to the
// car and truck object blocks.
module enemy_spawn_ctrl #(
    parameter int          MIN_GAP_FRAMES = 30,
    parameter int          GAP_RANGE_LOG2 = 5,
    parameter logic [8:0]  TRUCK_THRESH   = 9'd64,
    parameter int          LANE_BITS      = 2,
    parameter logic [10:0] LANE_X0        = 11'd160,
    parameter logic [10:0] LANE_W         = 11'd64,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        game_enable,
    input  logic        object_exited,
    input  logic        object_hit,
    output logic        object_ready,
    output logic        create_truck,
    output logic [10:0] spawn_x,
    output logic        active,
    output logic [7:0]  spawn_count
);

    localparam int          GAP_W     = 16;
    // A zero-width random range collapses to a zero mask, giving a fixed gap.
    localparam logic [15:0] GAP_MASK  = 16'((32'd1 << GAP_RANGE_LOG2) - 32'd1);
    localparam logic [15:0] MIN_GAP   = 16'(MIN_GAP_FRAMES);
    localparam logic [10:0] LANE_MASK = 11'((32'd1 << LANE_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, GAP, SPAWN, ACTIVE} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_reload;
    logic               truck_pick;
    logic [10:0]        lane_idx;
    logic [10:0]        x_pick;

    // Spawn counter saturates instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // One step of the right-shifting Galois LFSR (taps 16,14,13,11).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    assign gap_reload = MIN_GAP + (lfsr & GAP_MASK);
    assign truck_pick = ({1'b0, lfsr[15:8]} < TRUCK_THRESH);
    assign lane_idx   = 11'(lfsr) & LANE_MASK;
    assign x_pick     = LANE_X0 + lane_idx * LANE_W;

    // Free-running random source; advances every clock regardless of state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr_next(lfsr);
    end

    // Spawn FSM with registered outputs; game_enable low overrides everything.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            object_ready <= 1'b0;
            create_truck <= 1'b0;
            spawn_x      <= LANE_X0;
            active       <= 1'b0;
            spawn_count  <= 8'd0;
        end else begin
            object_ready <= 1'b0;
            if (!game_enable) begin
                // Freeze: type, lane and count hold; partial gap is discarded.
                state  <= IDLE;
                active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        gap_cnt <= gap_reload;
                        state   <= GAP;
                    end
                    GAP: begin
                        if (startOfFrame) begin
                            if (gap_cnt <= 16'd1) begin
                                // Type, lane, pulse and count all become visible
                                // together in the SPAWN cycle.
                                state        <= SPAWN;
                                create_truck <= truck_pick;
                                spawn_x      <= x_pick;
                                object_ready <= 1'b1;
                                spawn_count  <= sat_inc8(spawn_count);
                            end else begin
                                gap_cnt <= gap_cnt - 16'd1;
                            end
                        end
                    end
                    SPAWN: begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                    end
                    ACTIVE: begin
                        // A frame tick in this same cycle is not counted.
                        if (object_exited || object_hit) begin
                            state   <= GAP;
                            active  <= 1'b0;
                            gap_cnt <= gap_reload;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Directed bench for enemy_spawn_ctrl: two instances (fixed 30-frame gap with
// trucks disabled, and 1-frame gap with trucks forced) share clock, reset and
// frame tick. Expected spawns are queued when the deciding frame tick is driven
// and popped when object_ready is seen.
module tb_enemy_spawn_ctrl;

    localparam logic [8:0] THR0 = 9'd0;
    localparam logic [8:0] THR1 = 9'd256;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic        en0 = 1'b0, ex0 = 1'b0, hit0 = 1'b0;
    logic        en1 = 1'b0, ex1 = 1'b0, hit1 = 1'b0;

    logic        d0_ready, d0_truck, d0_active;
    logic [10:0] d0_x;
    logic [7:0]  d0_count;
    logic        d1_ready, d1_truck, d1_active;
    logic [10:0] d1_x;
    logic [7:0]  d1_count;

    typedef struct {
        int          cyc;
        logic        truck;
        logic [10:0] x;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] m_lfsr;
    logic [10:0] last_x0;
    logic        last_t0;

    always #5 clk = ~clk;

    enemy_spawn_ctrl #(
        .MIN_GAP_FRAMES(30), .GAP_RANGE_LOG2(0), .TRUCK_THRESH(THR0),
        .LANE_BITS(2), .LANE_X0(11'd160), .LANE_W(11'd64), .LFSR_SEED(16'hACE1)
    ) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .game_enable(en0),
        .object_exited(ex0), .object_hit(hit0), .object_ready(d0_ready),
        .create_truck(d0_truck), .spawn_x(d0_x), .active(d0_active),
        .spawn_count(d0_count)
    );

    enemy_spawn_ctrl #(
        .MIN_GAP_FRAMES(1), .GAP_RANGE_LOG2(0), .TRUCK_THRESH(THR1),
        .LANE_BITS(2), .LANE_X0(11'd160), .LANE_W(11'd64), .LFSR_SEED(16'hACE1)
    ) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .game_enable(en1),
        .object_exited(ex1), .object_hit(hit1), .object_ready(d1_ready),
        .create_truck(d1_truck), .spawn_x(d1_x), .active(d1_active),
        .spawn_count(d1_count)
    );

    // Reference random sequence: 16-bit Galois LFSR, mask B400, seed ACE1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue the spawn that the frame tick driven now must produce next edge.
    task automatic push(input int which);
        exp_t e;
        e.cyc = cyc + 1;
        e.x   = 11'd160 + 11'(m_lfsr[1:0]) * 11'd64;
        if (which == 0) begin
            e.truck = ({1'b0, m_lfsr[15:8]} < THR0);
            q0.push_back(e);
            last_x0 = e.x;
            last_t0 = e.truck;
        end else begin
            e.truck = ({1'b0, m_lfsr[15:8]} < THR1);
            q1.push_back(e);
        end
    endtask

    // Advance one clock, sample just after the edge, score any spawn pulses.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (d0_ready) begin
            if (q0.size() == 0) chk("d0_unexpected_spawn", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("d0_spawn_cycle", 32'(cyc), 32'(e.cyc));
                chk("d0_truck", 32'(d0_truck), 32'(e.truck));
                chk("d0_spawn_x", 32'(d0_x), 32'(e.x));
            end
        end
        if (d1_ready) begin
            if (q1.size() == 0) chk("d1_unexpected_spawn", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("d1_spawn_cycle", 32'(cyc), 32'(e.cyc));
                chk("d1_truck", 32'(d1_truck), 32'(e.truck));
                chk("d1_spawn_x", 32'(d1_x), 32'(e.x));
            end
        end
    endtask

    // One 4-clock frame; optional stray exited pulse after the tick.
    task automatic frame(input bit noise);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        if (noise) ex0 = 1'b1;
        tick();
        ex0 = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [31:0] in_lane_set(input logic [10:0] x);
        return (x == 11'd160 || x == 11'd224 || x == 11'd288 || x == 11'd352) ? 32'd1 : 32'd0;
    endfunction

    initial begin
        // Reset held with enables and frame ticks toggling: nothing may move.
        en0 = 1'b1;
        en1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sof = ~sof;
            tick();
        end
        chk("rst_ready", 32'(d0_ready), 32'd0);
        chk("rst_truck", 32'(d0_truck), 32'd0);
        chk("rst_x", 32'(d0_x), 32'd160);
        chk("rst_active", 32'(d0_active), 32'd0);
        chk("rst_count", 32'(d0_count), 32'd0);
        chk("rst_d1_count", 32'(d1_count), 32'd0);
        en0 = 1'b0;
        en1 = 1'b0;
        sof = 1'b0;
        tick();
        resetN = 1'b1;
        tick();

        // First spawn after exactly 30 frame ticks.
        en0 = 1'b1;
        tick();
        repeat (29) frame(1'b0);
        chk("gap29_count", 32'(d0_count), 32'd0);
        chk("gap29_active", 32'(d0_active), 32'd0);
        push(0);
        frame(1'b0);
        chk("spawn1_seen", 32'(q0.size()), 32'd0);
        chk("spawn1_count", 32'(d0_count), 32'd1);
        chk("spawn1_active", 32'(d0_active), 32'd1);
        chk("spawn1_lane", in_lane_set(d0_x), 32'd1);

        // 19 more spawns: hit/exit with a coincident frame tick, stray exits in GAP.
        for (int i = 1; i < 20; i++) begin
            hit0 = (i % 3 != 1);
            ex0  = (i % 3 != 0);
            sof  = 1'b1;
            tick();
            hit0 = 1'b0;
            ex0  = 1'b0;
            sof  = 1'b0;
            tick();
            chk("left_active", 32'(d0_active), 32'd0);
            tick();
            tick();
            repeat (29) frame(1'b1);
            chk("no_early_spawn", 32'(d0_count), 32'(i));
            push(0);
            frame(1'b0);
            chk("spawn_seen", 32'(q0.size()), 32'd0);
            chk("spawn_count", 32'(d0_count), 32'(i + 1));
            chk("spawn_active", 32'(d0_active), 32'd1);
            chk("spawn_lane", in_lane_set(d0_x), 32'd1);
        end

        // Disable at gap_cnt=10: outputs hold, re-enable needs a full 30 frames.
        hit0 = 1'b1;
        sof  = 1'b1;
        tick();
        hit0 = 1'b0;
        sof  = 1'b0;
        tick();
        tick();
        tick();
        repeat (20) frame(1'b0);
        en0 = 1'b0;
        tick();
        chk("dis_active", 32'(d0_active), 32'd0);
        chk("dis_truck", 32'(d0_truck), 32'(last_t0));
        chk("dis_x", 32'(d0_x), 32'(last_x0));
        chk("dis_count", 32'(d0_count), 32'd20);
        repeat (15) frame(1'b1);
        chk("dis_no_spawn", 32'(d0_count), 32'd20);
        en0 = 1'b1;
        tick();
        repeat (29) frame(1'b0);
        chk("reen_no_resume", 32'(d0_count), 32'd20);
        push(0);
        frame(1'b0);
        chk("reen_spawn_seen", 32'(q0.size()), 32'd0);
        chk("reen_count", 32'(d0_count), 32'd21);
        en0 = 1'b0;
        tick();

        // 300 back-to-back spawns on the 1-frame, all-truck instance.
        en1 = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            push(1);
            frame(1'b0);
            if (i == 253) chk("d1_count_254", 32'(d1_count), 32'd254);
            if (i == 254) chk("d1_count_255", 32'(d1_count), 32'd255);
            hit1 = 1'b1;
            tick();
            hit1 = 1'b0;
        end
        chk("d1_spawns_seen", 32'(q1.size()), 32'd0);
        chk("d1_count_sat", 32'(d1_count), 32'd255);
        chk("d0_quiet", 32'(d0_count), 32'd21);

        // Asynchronous reset mid-operation takes effect without a clock edge.
        resetN = 1'b0;
        #1;
        chk("arst_d1_count", 32'(d1_count), 32'd0);
        chk("arst_d1_truck", 32'(d1_truck), 32'd0);
        chk("arst_d1_x", 32'(d1_x), 32'd160);
        chk("arst_d0_count", 32'(d0_count), 32'd0);
        chk("arst_d1_ready", 32'(d1_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
